// File: rtl/rgb_to_yuv.sv
// ============================================================================
//  Module   : rgb_to_yuv
//  Purpose  : Packs pixel pairs into a 4:2:2 byte stream (U,Y1,V,Y2).
//             Macro RGB_TO_YUV_CHROMA_AVG_EN averages chroma over both pixels.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_to_yuv (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);

  typedef enum logic [2:0] {
    S_P1  = 3'd0,
    S_P2  = 3'd1,
    S_OU  = 3'd2,
    S_OY1 = 3'd3,
    S_OV  = 3'd4,
    S_OY2 = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [23:0] pix1;
  logic [23:0] pix2;

  // Max sum is 8*255+4 = 2044, so 11 bits hold it without overflow.
  function automatic logic [7:0] luma(input logic [23:0] p);
    logic [10:0] s;
    s = {2'b00, p[23:16], 1'b0}
      + {1'b0, p[15:8], 2'b00}
      + {3'b000, p[15:8]}
      + {3'b000, p[7:0]}
      + 11'd4;
    return s[10:3];
  endfunction

  function automatic logic signed [13:0] diff(input logic [7:0] a, input logic [7:0] b);
    return $signed({6'b0, a}) - $signed({6'b0, b});
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [13:0] x);
    logic [7:0] r;
    if (x > 14'sd127)
      r = 8'h7F;
    else if (x < -14'sd128)
      r = 8'h80;
    else
      r = x[7:0];
    return r;
  endfunction

  logic [7:0]         y1;
  logic [7:0]         y2;
  logic signed [13:0] b_y1;
  logic signed [13:0] r_y1;
  logic signed [13:0] u_raw;
  logic signed [13:0] v_raw;
  logic [7:0]         u_byte;
  logic [7:0]         v_byte;

  assign y1   = luma(pix1);
  assign y2   = luma(pix2);
  assign b_y1 = diff(pix1[7:0], y1);
  assign r_y1 = diff(pix1[23:16], y1);

`ifdef RGB_TO_YUV_CHROMA_AVG_EN
  logic signed [13:0] b_y2;
  logic signed [13:0] r_y2;

  assign b_y2  = diff(pix2[7:0], y2);
  assign r_y2  = diff(pix2[23:16], y2);
  assign u_raw = (b_y1 + b_y2 + 14'sd2) >>> 2;
  assign v_raw = (14'sd5 * (r_y1 + r_y2) + 14'sd8) >>> 4;
`else
  assign u_raw = (b_y1 + 14'sd1) >>> 1;
  assign v_raw = (14'sd5 * r_y1 + 14'sd4) >>> 3;
`endif

  assign u_byte = clamp8(u_raw);
  assign v_byte = clamp8(v_raw);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_P1;
      pix1  <= 24'h000000;
      pix2  <= 24'h000000;
    end else begin
      state <= state_next;
      if (state == S_P1 && in_en)
        pix1 <= rgb_in;
      if (state == S_P2 && in_en)
        pix2 <= rgb_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_P1:    if (in_en) state_next = S_P2;
      S_P2:    if (in_en) state_next = S_OU;
      S_OU:    state_next = S_OY1;
      S_OY1:   state_next = S_OV;
      S_OV:    state_next = S_OY2;
      S_OY2:   state_next = S_P1;
      default: state_next = S_P1;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    yuv_out = 8'h00;
    case (state)
      S_OU:  begin busy = 1'b1; yuv_out = u_byte; end
      S_OY1: begin busy = 1'b1; yuv_out = y1;     end
      S_OV:  begin busy = 1'b1; yuv_out = v_byte; end
      S_OY2: begin busy = 1'b1; yuv_out = y2;     end
      default: ;
    endcase
  end

  assign out_valid = busy;

endmodule

`default_nettype wire

// File: doc/rgb_to_yuv.md
RGB_TO_YUV -- requirements
Module: rgb_to_yuv

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_en  input  1  rgb_in carries a valid pixel this cycle.
REQ-004 SHALL have ports: rgb_in  input  24  pixel {R[23:16],G[15:8],B[7:0]}, unsigned.
REQ-005 SHALL have ports: busy  output  1  high while the block cannot accept pixels.
REQ-006 SHALL have ports: out_valid  output  1  yuv_out carries a valid byte this cycle.
REQ-007 SHALL have ports: yuv_out  output  8  4:2:2 byte stream, order U,Y1,V,Y2.
REQ-008 SHALL use one clock (clk), with reset synchronous and active-high; no parameters.

Function
REQ-009 SHALL use FSM states S_P1, S_P2, S_OU, S_OY1, S_OV, S_OY2.
REQ-010 In S_P1, in_en=1 SHALL capture rgb_in as pixel 1 and go to S_P2; in_en=0 SHALL hold state.
REQ-011 In S_P2, in_en=1 SHALL capture rgb_in as pixel 2 and go to S_OU; in_en=0 SHALL hold state and pixel 1.
REQ-012 S_OU->S_OY1->S_OV->S_OY2->S_P1 SHALL advance unconditionally, one state per cycle.
REQ-013 busy SHALL be 1 exactly in S_OU..S_OY2 (decoded from state); in_en and rgb_in SHALL be ignored while busy=1.
REQ-014 out_valid SHALL equal busy; yuv_out SHALL be U, Y1, V, Y2 in S_OU, S_OY1, S_OV, S_OY2 respectively, and 8'h00 otherwise.
REQ-015 Latency: with pixel 2 accepted at edge k, U SHALL appear in the cycle after edge k, followed by three consecutive bytes; S_P1 SHALL be re-entered at edge k+4.
REQ-016 Luma: Yn = (2*Rn + 5*Gn + Bn + 4) >> 3, unsigned, range 0..255 without clamping.
REQ-017 Chroma arithmetic SHALL be signed two's complement in at least 14 bits; >>> denotes arithmetic right shift (floor).
REQ-018 U and V SHALL be clamped to [-128,127] and output as 8-bit two's complement, matching the sign-extended U/V format the downstream YUV-to-RGB stage consumes.
REQ-019 Pixel registers SHALL hold their value outside the capture cycles of REQ-010 and REQ-011.

Reset
REQ-020 reset=1 at an edge SHALL force S_P1 and clear both pixel registers, regardless of state, including mid-output.
REQ-021 After reset: busy=0, out_valid=0, yuv_out=8'h00; a partially emitted group SHALL be discarded, not resumed.
REQ-022 reset SHALL take priority over in_en in the same cycle.

Configuration
REQ-023 Macro RGB_TO_YUV_CHROMA_AVG_EN defined: U = ((B1-Y1)+(B2-Y2)+2) >>> 2; V = (5*((R1-Y1)+(R2-Y2))+8) >>> 4.
REQ-024 Macro RGB_TO_YUV_CHROMA_AVG_EN undefined: U = ((B1-Y1)+1) >>> 1; V = (5*(R1-Y1)+4) >>> 3; pixel 2 SHALL contribute only Y2.
REQ-025 The macro SHALL NOT change the FSM, timing or luma.

Verification
REQ-026 Two white pixels 24'hFFFFFF -> bytes 00,FF,00,FF, out_valid high for exactly 4 cycles.
REQ-027 Two red pixels 24'hFF0000 -> E0,40,77,40 (both macro settings).
REQ-028 Two blue pixels 24'h0000FF -> 70,20,EC,20 (both macro settings).
REQ-029 Red then blue -> with macro 28,40,32,20; without macro E0,40,77,20.
REQ-030 in_en=0 for 3 cycles between pixel 1 and pixel 2, in_en held high during busy -> one group only, no extra capture, same bytes as the back-to-back case.
REQ-031 Assert reset during S_OV -> next cycle busy=0, out_valid=0, yuv_out=00; a new pixel pair then produces a correct full group.
